// File: rtl/dequant_zigzag.sv
// dequant_zigzag: dequantizes zigzag-ordered coefficients into double-buffered raster 8x8 blocks
module dequant_zigzag #(
   parameter int NUM_QT = 4,
   parameter int QT_W   = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      qt_we,
   input  logic [$clog2(NUM_QT)-1:0] qt_id,
   input  logic [5:0]                qt_addr,
   input  logic [QT_W-1:0]           qt_data,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic signed [15:0]        s_data,
   input  logic [$clog2(NUM_QT)-1:0] s_qt_sel,
   input  logic                      s_eob,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [1023:0]             m_data
);
   typedef enum logic [1:0] {IDLE, FILL, ZFILL} state_t;
   localparam logic [5:0] ZZ_NAT [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};
   logic [QT_W-1:0]           qt [NUM_QT][64];
   logic signed [15:0]        bank [2][64];
   logic [1:0]                full;
   logic                      wr_ptr, rd_ptr, init;
   logic [5:0]                zz;
   logic [$clog2(NUM_QT)-1:0] sel_q, sel;
   state_t                    state, state_n;
   logic                      xfer, wr_en, done, hs;
   logic signed [24:0]        prod;
   logic signed [15:0]        wr_val;
   assign s_ready = init && state != ZFILL && !full[wr_ptr];
   assign xfer    = s_valid && s_ready;
   assign wr_en   = xfer || state == ZFILL;
   assign done    = wr_en && zz == 6'd63;
   assign m_valid = full[rd_ptr];
   assign hs      = m_valid && m_ready;
   assign sel     = state == IDLE ? s_qt_sel : sel_q;
   assign prod    = s_data * $signed({1'b0, qt[sel][zz]});
   // quantization tables: plain write port, reads see the pre-write value
   always_ff @(posedge clk)
      if (qt_we) qt[qt_id][qt_addr] <= qt_data;
   // saturate the product, or zero-fill after end-of-block
   always_comb begin
      wr_val = '0;
      if (state != ZFILL)
         wr_val = prod > 25'sd32767 ? 16'sh7fff : prod < -25'sd32768 ? 16'sh8000 : prod[15:0];
   end
   // fill FSM next state: completion wins over an eob on the last index
   always_comb begin
      state_n = state;
      state_n = done ? IDLE : (xfer && s_eob) ? ZFILL : xfer ? FILL : state;
   end
   // fill/read pointers, bank occupancy, zigzag counter and latched table id
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state  <= IDLE;
         zz     <= '0;
         sel_q  <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         full   <= '0;
         init   <= 1'b0;
      end else begin
         init  <= 1'b1;
         state <= state_n;
         if (state == IDLE && xfer) sel_q <= s_qt_sel;
         zz <= done ? 6'd0 : wr_en ? zz + 6'd1 : zz;
         if (done) wr_ptr <= ~wr_ptr;
         if (hs) rd_ptr <= ~rd_ptr;
         full <= (full & ~({1'b0, hs} << rd_ptr)) | ({1'b0, done} << wr_ptr);
      end
   // coefficient banks, written at the raster position of the current zigzag index
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int b = 0; b < 2; b++)
            for (int k = 0; k < 64; k++)
               bank[b][k] <= '0;
      end else if (wr_en) begin
         bank[wr_ptr][ZZ_NAT[zz]] <= wr_val;
      end
   // present the read bank as one flat word
   always_comb begin
      m_data = '0;
      for (int k = 0; k < 64; k++)
         m_data[16*k +: 16] = bank[rd_ptr][k];
   end
endmodule

// File: tb/tb_dequant_zigzag.sv
// tb_dequant_zigzag: vector table, directed corner cases and random blocks against a block-level model
module tb_dequant_zigzag;
   logic clk = 0, rst_n = 0, qt_we = 0, s_valid = 0, s_eob = 0, m_ready = 0;
   logic [1:0] qt_id = 0, s_qt_sel = 0;
   logic [5:0] qt_addr = 0;
   logic [7:0] qt_data = 0;
   logic signed [15:0] s_data = 0;
   logic s_ready, m_valid;
   logic [1023:0] m_data;
   int pass_cnt = 0, total = 0, hs_cnt = 0, push_cnt = 0, mr_mode = 0;
   bit qwr_mode = 0, gaps = 0;
   logic [7:0] qt_m [4][64];
   int nat [64];
   logic [1023:0] exp_q [$];
   typedef struct {int d; int q; int e;} vec_t;
   vec_t vecs [12];

   always #5 clk = ~clk;

   dequant_zigzag #(.NUM_QT(4), .QT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .qt_we(qt_we), .qt_id(qt_id), .qt_addr(qt_addr),
      .qt_data(qt_data), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_qt_sel(s_qt_sel), .s_eob(s_eob), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data));

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic chk_blk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
      int k = 0;
      total++;
      if (act == exp) begin
         pass_cnt++;
         return;
      end
      while (k < 63 && act[16*k +: 16] == exp[16*k +: 16]) k++;
      $display("FAIL %s: k=%0d got %0d expected %0d", nm, k,
               $signed(act[16*k +: 16]), $signed(exp[16*k +: 16]));
   endtask

   function automatic logic [15:0] sat(input int d, input int q);
      int p = d * q;
      return p > 32767 ? 16'h7fff : p < -32768 ? 16'h8000 : 16'(p);
   endfunction

   // every block taken downstream must be the oldest completed block
   always @(negedge clk)
      if (rst_n && m_valid && m_ready) begin
         hs_cnt++;
         if (exp_q.size() == 0) chk("extra_block", hs_cnt, push_cnt);
         else chk_blk("block_data", m_data, exp_q.pop_front());
      end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick(output bit t);
      @(negedge clk);
      t = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (qt_we) qt_m[qt_id][qt_addr] = qt_data;
      qt_we = qwr_mode && $urandom_range(3) == 0;
      qt_id = 2'($urandom);
      qt_addr = 6'($urandom);
      qt_data = 8'($urandom);
      m_ready = mr_mode == 2 ? 1'($urandom) : mr_mode == 1;
   endtask

   task automatic set_mr(input int m);
      mr_mode = m;
      m_ready = m == 1;
   endtask

   task automatic load_tab(input int id, input int val);
      bit t;
      for (int a = 0; a < 64; a++) begin
         qt_we = 1;
         qt_id = 2'(id);
         qt_addr = 6'(a);
         qt_data = val < 0 ? 8'($urandom) : 8'(val);
         tick(t);
      end
   endtask

   // dmode: 0 = zigzag index, 1 = constant cval, 2 = random with extremes
   task automatic send(input int sel, input int eob_at, input int n, input int dmode,
                       input int cval, input bit mr_last);
      logic [1023:0] blk = '0;
      logic [15:0] v;
      bit t;
      int to;
      for (int zz = 0; zz < n; zz++) begin
         if (gaps && $urandom_range(3) == 0) begin
            s_valid = 0;
            tick(t);
         end
         s_valid = 1;
         s_eob = zz == eob_at;
         s_qt_sel = zz == 0 ? 2'(sel) : 2'($urandom);
         if (dmode == 0) s_data = 16'(zz);
         else if (dmode == 1) s_data = 16'(cval);
         else if ($urandom_range(3) == 0) s_data = $urandom_range(1) == 1 ? 16'sh7fff : 16'sh8000;
         else s_data = 16'($urandom_range(4000)) - 16'sd2000;
         if (mr_last && zz == 63) set_mr(1);
         v = sat(int'(s_data), int'(qt_m[sel][zz]));
         to = 0;
         do begin
            tick(t);
            to++;
         end while (!t && to < 1000);
         if (!t) begin
            chk("xfer_timeout", to, 0);
            s_valid = 0;
            return;
         end
         blk[16*nat[zz] +: 16] = v;
         if (zz == eob_at || zz == 63) begin
            s_valid = 0;
            s_eob = 0;
            exp_q.push_back(blk);
            push_cnt++;
            return;
         end
      end
      s_valid = 0;
      s_eob = 0;
   endtask

   task automatic wait_valid();
      bit t;
      int to = 0;
      while (!m_valid && to < 200) begin
         tick(t);
         to++;
      end
      chk("wait_m_valid", m_valid, 1);
   endtask

   task automatic drain();
      bit t;
      int to = 0;
      set_mr(1);
      while (exp_q.size() != 0 && to < 1000) begin
         tick(t);
         to++;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      bit t;
      int cnt, z, c;
      vecs = '{'{-3000, 16, -32768}, '{100, 255, 25500}, '{200, 255, 32767},
               '{-128, 255, -32640}, '{-129, 255, -32768}, '{32767, 1, 32767},
               '{-32768, 1, -32768}, '{5, 0, 0}, '{-1, 255, -255},
               '{129, 255, 32767}, '{-32768, 255, -32768}, '{1234, 3, 3702}};
      // raster position of each zigzag index: walk anti-diagonals, alternating direction
      z = 0;
      for (int s = 0; s < 15; s++)
         for (int i = 0; i < 8; i++) begin
            int r;
            r = (s % 2 == 0) ? 7 - i : i;
            c = s - r;
            if (c >= 0 && c < 8) begin
               nat[z] = r * 8 + c;
               z++;
            end
         end

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk_blk("rst_m_data", m_data, '0);
      rst_n = 1;
      chk("release_s_ready", s_ready, 0);
      tick(t);
      chk("ready_after_reset", s_ready, 1);

      // natural ordering with unit tables
      for (int id = 0; id < 4; id++) load_tab(id, 1);
      send(0, 64, 64, 0, 0, 0);
      chk("t1_m_valid", m_valid, 1);
      chk("t1_k8", m_data[16*8 +: 16], 2);
      chk("t1_k16", m_data[16*16 +: 16], 3);
      chk("t1_k63", m_data[16*63 +: 16], 63);
      drain();

      // eob at the first index: 63 zero-fill cycles and negative saturation
      set_mr(0);
      load_tab(0, 16);
      send(0, 0, 64, 1, -3000, 0);
      cnt = 0;
      while (cnt < 200) begin
         @(negedge clk);
         if (s_ready) break;
         cnt++;
      end
      chk("zfill_stall", cnt, 63);
      @(posedge clk);
      #1;
      chk("t2_m_valid", m_valid, 1);
      chk("t2_k0", $signed(m_data[15:0]), -32768);
      drain();

      // saturation and arithmetic vectors
      foreach (vecs[i]) begin
         set_mr(0);
         qt_we = 1;
         qt_id = 3;
         qt_addr = 0;
         qt_data = 8'(vecs[i].q);
         tick(t);
         send(3, 0, 64, 1, vecs[i].d, 0);
         wait_valid();
         chk($sformatf("vec%0d", i), $signed(m_data[15:0]), vecs[i].e);
         drain();
      end

      // backpressure with both banks full
      set_mr(0);
      send(0, 64, 64, 2, 0, 0);
      send(0, 64, 64, 2, 0, 0);
      s_valid = 1;
      s_data = 1;
      s_qt_sel = 0;
      @(negedge clk);
      chk("bp_s_ready", s_ready, 0);
      chk("bp_m_valid", m_valid, 1);
      @(posedge clk);
      #1;
      set_mr(1);
      @(negedge clk);
      chk("bp_hs_s_ready", s_ready, 0);
      @(posedge clk);
      #1;
      chk("bp_release", s_ready, 1);
      s_valid = 0;
      send(0, 64, 64, 2, 0, 0);
      drain();

      // table selection latched per block
      load_tab(1, 2);
      load_tab(2, 5);
      set_mr(0);
      send(1, 64, 64, 1, 7, 0);
      send(2, 64, 64, 1, 7, 0);
      chk("t4_a_k37", $signed(m_data[16*37 +: 16]), 14);
      set_mr(1);
      tick(t);
      set_mr(0);
      chk("t4_b_k37", $signed(m_data[16*37 +: 16]), 35);
      drain();

      // reset in the middle of a block
      set_mr(0);
      send(0, 64, 64, 2, 0, 0);
      send(0, 64, 30, 2, 0, 0);
      chk("pre_reset_valid", m_valid, 1);
      rst_n = 0;
      #1;
      chk("reset_m_valid", m_valid, 0);
      chk("reset_s_ready", s_ready, 0);
      push_cnt -= exp_q.size();
      exp_q.delete();
      @(posedge clk);
      #1;
      chk_blk("reset_m_data", m_data, '0);
      rst_n = 1;
      tick(t);
      set_mr(1);
      send(1, 64, 64, 2, 0, 0);
      drain();

      // completion on the same edge as the earlier block's handshake
      set_mr(0);
      send(2, 64, 64, 2, 0, 0);
      send(1, 64, 64, 2, 0, 1);
      chk("overlap_m_valid", m_valid, 1);
      drain();

      // random blocks, eob positions, table writes, gaps and backpressure
      for (int id = 0; id < 4; id++) load_tab(id, -1);
      qwr_mode = 1;
      gaps = 1;
      mr_mode = 2;
      for (int b = 0; b < 10; b++)
         send(int'($urandom_range(3)), $urandom_range(3) == 0 ? 64 : int'($urandom_range(63)),
              64, 2, 0, 0);
      qwr_mode = 0;
      gaps = 0;
      drain();
      chk("block_count", hs_cnt, push_cnt);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
